cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Transmitting end of the common data bus (CDB).
- Collects completed results (tag + data) from up to NUM_SRC functional units (ALU RS, MUL RS, load unit, ...).
- Buffers each source's results in a small per-source FIFO.
- Drives exactly one registered broadcast per clock onto the CDB, chosen by round-robin arbitration.
- The reservation stations snoop this broadcast via their CDB is_cast/tag/data inputs.

Parameters:
- NUM_SRC, 4, number of producing functional units.
- TAG_W, 6, tag width.
- DATA_W, 32, result data width.
- FIFO_DEPTH, 2, entries per source FIFO (power of two, >=2).

Ports:
- in_clock  input  1  clock, all state on rising edge.
- in_reset_n  input  1  reset, synchronous, active-low.
- in_src_valid  input  NUM_SRC  bit i: source i presents a result this cycle.
- in_src_tag  input  NUM_SRC*TAG_W  source i tag at bits [i*TAG_W +: TAG_W].
- in_src_data  input  NUM_SRC*DATA_W  source i data at bits [i*DATA_W +: DATA_W].
- out_src_ready  output  NUM_SRC  bit i: source i FIFO can accept this cycle.
- out_CDB_is_cast  output  1  broadcast valid, one-cycle pulse per result.
- out_CDB_tag  output  TAG_W  broadcast tag.
- out_CDB_data  output  DATA_W  broadcast data.
- out_pending  output  1  any source FIFO non-empty.

Behaviour:
- Reset (in_reset_n=0 at a rising edge):
  - all FIFOs empty; round-robin pointer = 0.
  - out_CDB_is_cast=0, out_CDB_tag=6'h3F (INVALID_TAG), out_CDB_data=0.
  - Reset mid-operation discards all buffered results; no broadcast on the cycle after reset.
- out_src_ready[i] = (count_i < FIFO_DEPTH), combinational from registered count.
  - No pass-through when full: a simultaneous pop does not raise ready in the same cycle.
- Push: valid[i] & ready[i] at an edge enqueues {tag,data}.
  - valid while not ready is ignored, not latched; the source must hold its result.
- Tag == INVALID_TAG with valid=1 and ready=1: handshake completes, result dropped, never broadcast.
- Arbitration:
  - Each cycle, scan sources ptr, ptr+1, ..., ptr+NUM_SRC-1 (mod NUM_SRC).
  - The first non-empty FIFO wins.
  - Its head is popped and registered onto out_CDB_* at this edge; out_CDB_is_cast=1 for exactly that cycle.
  - ptr <= (winner+1) mod NUM_SRC.
- No FIFO non-empty:
  - out_CDB_is_cast=0; tag/data hold their previous values; ptr unchanged.
- Latency:
  - A result pushed at edge N into an otherwise empty arbiter broadcasts at edge N+1 (visible N+1 to N+2).
  - No combinational valid->CDB path.
- Push and pop on the same FIFO in the same cycle: count unchanged; FIFO order preserved.
- Throughput: 1 broadcast/cycle total. Each source receives at least one grant every NUM_SRC cycles while non-empty.
- FIFO pointers wrap modulo FIFO_DEPTH. count is clog2(FIFO_DEPTH)+1 bits and never exceeds FIFO_DEPTH (assertion).
- out_pending = OR of all non-empty flags; registered-state based.

Decomposition:
- Package cdb_pkg:
  - TAG_W, DATA_W, INVALID_TAG=6'h3F.
  - typedef cdb_entry_t {tag, data}.
  - typedef cdb_bus_t {is_cast, tag, data}.
  - Shared by all reservation stations and the ROB.
- Sub-module cdb_src_fifo: single-source synchronous FIFO (push/pop/full/empty/head), instantiated NUM_SRC times.
- The arbiter top contains the round-robin pointer, grant logic and output register.

Test Plan:
- Reset behaviour: hold in_reset_n=0 two cycles while valid=4'b1111 -> out_CDB_is_cast=0, tag=6'h3F, data=0, all FIFOs empty afterward, out_pending=0.
- Single result: source 1 pushes tag 6'h11, data 32'hDEADBEEF at edge N -> is_cast=1 after edge N+1 with that tag/data, 0 after edge N+2.
- Round-robin fairness: all four sources push one result the same cycle, ptr=0 -> broadcasts in order src0, src1, src2, src3 on four consecutive cycles, then ptr=0.
- Backpressure: source 2 pushes 3 results back-to-back while sources 0 and 1 stay busy.
  - out_src_ready[2]=0 once its count reaches 2.
  - The third result is accepted only after a src2 grant.
  - All three are broadcast in order: tags 6'h21, 6'h22, 6'h23.
- INVALID_TAG drop: source 3 pushes tag 6'h3F, data 5 -> handshake completes, no broadcast ever, out_pending stays 0.
- Reset mid-operation: fill FIFOs of sources 0 and 2, assert reset one cycle -> next cycle is_cast=0 and no stale entry is ever broadcast afterward.

Source files
------------

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared common data bus widths, tag encoding and bus types
package cdb_pkg;

    localparam int TAG_W  = 6;
    localparam int DATA_W = 32;

    // Tag value reserved to mean "no producer"; results carrying it are never broadcast.
    localparam logic [TAG_W-1:0] INVALID_TAG = 6'h3F;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_entry_t;

    typedef struct packed {
        logic              is_cast;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_bus_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source result FIFO feeding the CDB arbiter
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       push_i,
    input  cdb_entry_t entry_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output cdb_entry_t head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cdb_entry_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop) count_d = count_q + 1'b1;
        if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= entry_i;
    end

    a_count_bound: assert property (@(posedge clk_i) disable iff (!rstn_i) count_q <= CW'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving one registered CDB broadcast per cycle
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      in_clock,
    input  logic                      in_reset_n,
    input  logic [NUM_SRC-1:0]        in_src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]  in_src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] in_src_data,
    output logic [NUM_SRC-1:0]        out_src_ready,
    output logic                      out_CDB_is_cast,
    output logic [TAG_W-1:0]          out_CDB_tag,
    output logic [DATA_W-1:0]         out_CDB_data,
    output logic                      out_pending
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] full, empty, push, pop;
    cdb_entry_t         src_entry [NUM_SRC];
    cdb_entry_t         head      [NUM_SRC];

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      winner;
    logic               grant_vld;
    cdb_bus_t           bus_q, bus_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign src_entry[i] = '{tag:  in_src_tag[i*TAG_W +: TAG_W],
                                data: in_src_data[i*DATA_W +: DATA_W]};
        // An INVALID_TAG result still completes its handshake but is never stored.
        assign push[i] = in_src_valid[i] && !full[i] &&
                         (in_src_tag[i*TAG_W +: TAG_W] != INVALID_TAG);

        cdb_src_fifo #(
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (in_clock),
            .rstn_i  (in_reset_n),
            .push_i  (push[i]),
            .entry_i (src_entry[i]),
            .pop_i   (pop[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .head_o  (head[i])
        );
    end

    assign out_src_ready = ~full;
    assign out_pending   = ~&empty;

    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        grant_vld = 1'b0;
        winner    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = PW'((int'(ptr_q) + k) % NUM_SRC);
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                winner    = idx;
            end
        end
    end

    always_comb begin
        pop           = '0;
        ptr_d         = ptr_q;
        bus_d         = bus_q;
        bus_d.is_cast = 1'b0;
        if (grant_vld) begin
            pop           = NUM_SRC'(1) << winner;
            ptr_d         = (winner == PW'(NUM_SRC - 1)) ? '0 : winner + 1'b1;
            bus_d.is_cast = 1'b1;
            bus_d.tag     = head[winner].tag;
            bus_d.data    = head[winner].data;
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            ptr_q <= '0;
            bus_q <= '{is_cast: 1'b0, tag: INVALID_TAG, data: '0};
        end else begin
            ptr_q <= ptr_d;
            bus_q <= bus_d;
        end
    end

    assign out_CDB_is_cast = bus_q.is_cast;
    assign out_CDB_tag     = bus_q.tag;
    assign out_CDB_data    = bus_q.data;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter against a queue-based model
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int DW = 32;
    localparam int D  = 2;

    logic            in_clock = 1'b0;
    logic            in_reset_n;
    logic [N-1:0]    in_src_valid;
    logic [N*TW-1:0] in_src_tag;
    logic [N*DW-1:0] in_src_data;
    logic [N-1:0]    out_src_ready;
    logic            out_CDB_is_cast;
    logic [TW-1:0]   out_CDB_tag;
    logic [DW-1:0]   out_CDB_data;
    logic            out_pending;

    always #5 in_clock = ~in_clock;

    cdb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(D)) dut (
        .in_clock        (in_clock),
        .in_reset_n      (in_reset_n),
        .in_src_valid    (in_src_valid),
        .in_src_tag      (in_src_tag),
        .in_src_data     (in_src_data),
        .out_src_ready   (out_src_ready),
        .out_CDB_is_cast (out_CDB_is_cast),
        .out_CDB_tag     (out_CDB_tag),
        .out_CDB_data    (out_CDB_data),
        .out_pending     (out_pending)
    );

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per source, a round-robin start index and the last broadcast.
    logic [TW+DW-1:0] mq [N][$];
    int               mptr;
    logic             exp_cast;
    logic [TW-1:0]    exp_tag;
    logic [DW-1:0]    exp_data;

    always @(posedge in_clock) begin : model
        int               win;
        logic [N-1:0]     rdy;
        logic [TW+DW-1:0] e;
        logic [TW-1:0]    t;
        if (!in_reset_n) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            mptr     = 0;
            exp_cast = 1'b0;
            exp_tag  = 6'h3F;
            exp_data = '0;
        end else begin
            for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
            win = -1;
            for (int k = 0; k < N; k++)
                if (win < 0 && mq[(mptr + k) % N].size() > 0) win = (mptr + k) % N;
            if (win >= 0) begin
                e        = mq[win].pop_front();
                exp_cast = 1'b1;
                exp_tag  = e[TW+DW-1:DW];
                exp_data = e[DW-1:0];
                mptr     = (win + 1) % N;
            end else begin
                exp_cast = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                t = in_src_tag[i*TW +: TW];
                if (in_src_valid[i] && rdy[i] && t != 6'h3F)
                    mq[i].push_back({t, in_src_data[i*DW +: DW]});
            end
        end
    end

    always @(negedge in_clock) begin : compare
        logic [N-1:0] er;
        logic         ep;
        if (check_en) begin
            ep = 1'b0;
            for (int i = 0; i < N; i++) begin
                er[i] = (mq[i].size() < D);
                if (mq[i].size() > 0) ep = 1'b1;
            end
            chk("model_cast",    64'(out_CDB_is_cast), 64'(exp_cast));
            chk("model_tag",     64'(out_CDB_tag),     64'(exp_tag));
            chk("model_data",    64'(out_CDB_data),    64'(exp_data));
            chk("model_ready",   64'(out_src_ready),   64'(er));
            chk("model_pending", 64'(out_pending),     64'(ep));
        end
    end

    task automatic tick;
        @(negedge in_clock);
    endtask

    task automatic set_src(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
        in_src_valid[i]        = v;
        in_src_tag[i*TW +: TW] = t;
        in_src_data[i*DW +: DW] = d;
    endtask

    task automatic idle;
        in_src_valid = '0;
    endtask

    task automatic reset_pulse;
        idle();
        in_reset_n = 1'b0;
        tick();
        in_reset_n = 1'b1;
    endtask

    initial begin : stim
        logic [TW-1:0] got [$];
        int            sent;
        bit            saw_block;
        bit            acc;

        in_reset_n   = 1'b0;
        in_src_valid = '1;
        in_src_tag   = '0;
        in_src_data  = '1;
        tick();
        check_en = 1'b1;
        tick();
        chk("rst_cast",    64'(out_CDB_is_cast), 64'h0);
        chk("rst_tag",     64'(out_CDB_tag),     64'h3F);
        chk("rst_data",    64'(out_CDB_data),    64'h0);
        chk("rst_pending", 64'(out_pending),     64'h0);
        chk("rst_ready",   64'(out_src_ready),   64'hF);
        in_reset_n = 1'b1;
        idle();
        tick();
        chk("rst_idle_cast", 64'(out_CDB_is_cast), 64'h0);

        // Single result from source 1.
        set_src(1, 1'b1, 6'h11, 32'hDEADBEEF);
        tick();
        idle();
        chk("single_n_cast", 64'(out_CDB_is_cast), 64'h0);
        chk("single_n_pend", 64'(out_pending),     64'h1);
        tick();
        chk("single_cast", 64'(out_CDB_is_cast), 64'h1);
        chk("single_tag",  64'(out_CDB_tag),     64'h11);
        chk("single_data", 64'(out_CDB_data),    64'hDEADBEEF);
        tick();
        chk("single_off_cast", 64'(out_CDB_is_cast), 64'h0);
        chk("single_off_tag",  64'(out_CDB_tag),     64'h11);

        // Round-robin order from pointer 0.
        reset_pulse();
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 6'(6'h30 + i), 32'(100 + i));
        tick();
        idle();
        for (int k = 0; k < N; k++) begin
            tick();
            chk("rr_cast", 64'(out_CDB_is_cast), 64'h1);
            chk("rr_tag",  64'(out_CDB_tag),     64'(6'h30 + k));
        end
        set_src(3, 1'b1, 6'h3E, 32'h3);
        set_src(0, 1'b1, 6'h0E, 32'h0);
        tick();
        idle();
        tick();
        chk("rr_wrap_first",  64'(out_CDB_tag), 64'h0E);
        tick();
        chk("rr_wrap_second", 64'(out_CDB_tag), 64'h3E);
        tick();

        // Backpressure on source 2 while sources 0 and 1 stay busy.
        sent      = 0;
        saw_block = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            set_src(0, 1'b1, 6'h05, 32'(cyc));
            set_src(1, 1'b1, 6'h15, 32'(cyc));
            if (sent < 3) set_src(2, 1'b1, 6'(6'h21 + sent), 32'(200 + sent));
            else          set_src(2, 1'b0, 6'h00, 32'h0);
            acc = (sent < 3) && out_src_ready[2];
            if (sent < 3 && !out_src_ready[2]) saw_block = 1'b1;
            tick();
            if (acc) sent++;
            if (out_CDB_is_cast && out_CDB_tag[5:4] == 2'd2) got.push_back(out_CDB_tag);
            if (got.size() == 3) break;
        end
        idle();
        chk("bp_blocked", 64'(saw_block), 64'h1);
        chk("bp_count",   64'(got.size()), 64'h3);
        if (got.size() == 3) begin
            chk("bp_tag0", 64'(got[0]), 64'h21);
            chk("bp_tag1", 64'(got[1]), 64'h22);
            chk("bp_tag2", 64'(got[2]), 64'h23);
        end
        for (int k = 0; k < 8; k++) tick();

        // INVALID_TAG result is accepted but never broadcast.
        reset_pulse();
        set_src(3, 1'b1, 6'h3F, 32'h5);
        chk("inv_ready", 64'(out_src_ready[3]), 64'h1);
        tick();
        idle();
        for (int k = 0; k < 4; k++) begin
            chk("inv_pending", 64'(out_pending),     64'h0);
            chk("inv_cast",    64'(out_CDB_is_cast), 64'h0);
            tick();
        end

        // Reset with entries buffered in sources 0 and 2.
        set_src(0, 1'b1, 6'h0A, 32'hA0);
        set_src(2, 1'b1, 6'h2A, 32'hA2);
        tick();
        set_src(0, 1'b1, 6'h0B, 32'hB0);
        set_src(2, 1'b1, 6'h2B, 32'hB2);
        tick();
        idle();
        chk("mid_pend_before", 64'(out_pending), 64'h1);
        reset_pulse();
        chk("mid_cast",    64'(out_CDB_is_cast), 64'h0);
        chk("mid_pending", 64'(out_pending),     64'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_stale", 64'(out_CDB_is_cast), 64'h0);
        end

        // Randomized traffic with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_reset_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < N; i++)
                set_src(i, 1'($urandom_range(0, 2) != 0),
                        ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 62)),
                        $urandom);
            tick();
        end
        in_reset_n = 1'b1;
        idle();
        for (int k = 0; k < 12; k++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
